// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// rtl/mux_4_1_rr_arbiter_pkg.sv - shared types and sizes for the 4:1 round-robin arbiter mux
package mux_4_1_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic {IDLE, GRANT} state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] onehot(input sel_t s);
    return {{(N_REQ-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - first set bit of mask scanning base+1, base+2, base+3, base (mod 4)
module rr_pick_4
  import mux_4_1_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  sel_t             base,
  output sel_t             idx,
  output logic             any
);

  // Walk from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    idx = base;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (mask[base + sel_t'(k)]) begin
        idx = base + sel_t'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - round-robin arbitrated 4:1 valid/ready mux with registered grant
// Optional per-source handshake counters: MUX_4_1_RR_ARBITER_GRANT_CNT_EN
module mux_4_1_rr_arbiter
  import mux_4_1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [WIDTH-1:0]     req_data [0:N_REQ-1],
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output sel_t                 out_src,
  input  logic                 out_ready
`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]     grant_cnt [0:N_REQ-1]
`endif
);

  state_t state_q, state_d;
  sel_t   sel_q, sel_d;
  sel_t   ptr_q, ptr_d;

  logic             granted;
  logic             hs;
  logic [N_REQ-1:0] others;
  sel_t             hs_idx, idle_idx, idle_base;
  logic             hs_any, idle_any;

  assign granted   = (state_q == GRANT);
  assign hs        = granted & req_valid[sel_q] & out_ready;
  assign others    = req_valid & ~onehot(sel_q);
  assign idle_base = granted ? sel_q : ptr_q;

  rr_pick_4 u_pick_hs (
    .mask (others),
    .base (sel_q),
    .idx  (hs_idx),
    .any  (hs_any)
  );

  rr_pick_4 u_pick_idle (
    .mask (req_valid),
    .base (idle_base),
    .idx  (idle_idx),
    .any  (idle_any)
  );

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = '0;
    req_ready = '0;
    if (granted) begin
      out_valid          = req_valid[sel_q];
      out_data           = req_data[sel_q];
      out_src            = sel_q;
      req_ready[sel_q]   = out_ready;
    end
  end

  // A stalled grant holds sel/ptr; re-pick only after a handshake or when the granted source dropped.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (!granted) begin
      if (idle_any) begin
        sel_d   = idle_idx;
        state_d = GRANT;
      end
    end else if (hs) begin
      ptr_d = sel_q;
      if (hs_any) begin
        sel_d = hs_idx;
      end
    end else if (!req_valid[sel_q]) begin
      if (idle_any) begin
        sel_d = idle_idx;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= sel_t'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [0:N_REQ-1];
  logic [CNT_W-1:0] cnt_d [0:N_REQ-1];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs && (sel_q == sel_t'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - directed self-checking bench for mux_4_1_rr_arbiter
module tb_mux_4_1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_data [0:3];
  logic [3:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;
`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
  logic [15:0] grant_cnt [0:3];
`endif

  int errors = 0;
  int checks = 0;

  mux_4_1_rr_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = 4'h0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req_data[0] = 4'h1; req_data[1] = 4'h2; req_data[2] = 4'h4; req_data[3] = 4'h8;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", out_src); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL first_grant valid=%b src=%0d exp valid=1 src=0", out_valid, out_src); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready got=%b exp=0001", req_ready); end
    tick();
    checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL second_grant got=%0d exp=1", out_src); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'h0 || out_data !== 4'h0 || out_src !== 2'd0) begin
      errors++; $display("FAIL midreset_outputs valid=%b ready=%b data=%h src=%0d exp all 0", out_valid, req_ready, out_data, out_src);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL midreset_regrant valid=%b src=%0d exp valid=1 src=0", out_valid, out_src); end
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0100;
    req_data[2] = 4'hA;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      req_data[2] = 4'hA + 4'(k);
      #1;
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || req_ready !== 4'b0100) begin
        errors++; $display("FAIL single_beat%0d valid=%b src=%0d ready=%b exp 1/2/0100", k, out_valid, out_src, req_ready);
      end
      checks++; if (out_data !== 4'hA + 4'(k)) begin errors++; $display("FAIL single_data%0d got=%h exp=%h", k, out_data, 4'hA + 4'(k)); end
    end
    tick();
    req_valid = 4'h0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_contention;
    do_reset();
    req_data[0] = 4'h3; req_data[1] = 4'h5; req_data[2] = 4'h9; req_data[3] = 4'hC;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cont_idle got=%b exp=0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin
        errors++; $display("FAIL cont_src%0d valid=%b src=%0d exp valid=1 src=%0d", k, out_valid, out_src, k % 4);
      end
      checks++; if (out_data !== req_data[k % 4] || req_ready !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL cont_data%0d data=%h ready=%b exp data=%h ready=%b", k, out_data, req_ready, req_data[k % 4], 4'(1 << (k % 4)));
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req_data[1] = 4'h6; req_data[3] = 4'hE;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", out_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid = 4'b1010;
      #1;
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h6 || req_ready !== 4'h0) begin
        errors++; $display("FAIL bp_stall%0d valid=%b src=%0d data=%h ready=%b exp 1/1/6/0000", k, out_valid, out_src, out_data, req_ready);
      end
    end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (out_src !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release src=%0d ready=%b exp 1/0010", out_src, req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 4'hE || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_next valid=%b src=%0d data=%h ready=%b exp 1/3/E/1000", out_valid, out_src, out_data, req_ready);
    end
  endtask

  task automatic test_dropout;
    do_reset();
    req_data[0] = 4'h7;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h7) begin errors++; $display("FAIL drop_grant valid=%b src=%0d data=%h exp 1/0/7", out_valid, out_src, out_data); end
    tick();
    req_valid = 4'h0;
    #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("FAIL drop_gap valid=%b ready=%b exp 0/0001", out_valid, req_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL drop_to_idle valid=%b ready=%b exp 0/0000", out_valid, req_ready); end
    tick();
    req_valid = 4'b0001;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_reassert got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL drop_regrant valid=%b src=%0d exp 1/0", out_valid, out_src); end
  endtask

  task automatic test_reselect;
    do_reset();
    req_data[2] = 4'h5;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    tick();
    req_valid = 4'b0100;
    #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("FAIL resel_gap valid=%b ready=%b exp 0/0001", out_valid, req_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'h5) begin errors++; $display("FAIL resel_grant valid=%b src=%0d data=%h exp 1/2/5", out_valid, out_src, out_data); end
  endtask

`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
  task automatic test_grant_cnt;
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    checks++; if (grant_cnt[0] !== 16'd0 || grant_cnt[3] !== 16'd0) begin errors++; $display("FAIL cnt_reset c0=%0d c3=%0d exp 0/0", grant_cnt[0], grant_cnt[3]); end
    repeat (9) tick();
    req_valid = 4'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (grant_cnt[i] !== 16'd2) begin errors++; $display("FAIL cnt_contention%0d got=%0d exp=2", i, grant_cnt[i]); end
    end
    req_valid = 4'b0001;
    repeat (65545) tick();
    checks++; if (grant_cnt[0] !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=FFFF", grant_cnt[0]); end
    checks++; if (grant_cnt[1] !== 16'd2) begin errors++; $display("FAIL cnt_other got=%0d exp=2", grant_cnt[1]); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = 4'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 4'h0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_dropout();
    test_reselect();
`ifdef MUX_4_1_RR_ARBITER_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
